// File: rtl/regfile_sb.sv
// Architectural integer register file with a pending-write scoreboard.
// Write-back is sequential. The two decode read ports are combinational
// and see a same-cycle write through a bypass. A saturating per-register
// counter of in-flight writers lets decode detect RAW hazards and throttle
// issue.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_PEND = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy2,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_stall,
    output logic              wb_err
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = $clog2(MAX_PEND + 1);

    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_PEND);
    localparam logic [ADDR_W-1:0] ADDR_X0  = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic [DATA_W-1:0] regs_r [NREG];
    logic [CNT_W-1:0]  cnt_r  [NREG];
    logic              wb_err_r;

    logic [DATA_W-1:0] rdata1_s;
    logic [DATA_W-1:0] rdata2_s;
    logic              busy1_s;
    logic              busy2_s;
    logic              issue_stall_s;
    logic [NREG-1:0]   inc_s;
    logic [NREG-1:0]   dec_s;

    // Read port 1: reset/disable/x0 give zero, then bypass, then storage.
    always_comb begin
        rdata1_s = DATA_ZERO;
        busy1_s  = 1'b0;
        if (rst || !re1 || (raddr1 == ADDR_X0)) begin
            rdata1_s = DATA_ZERO;
            busy1_s  = 1'b0;
        end else begin
            if (we && (waddr == raddr1)) begin
                rdata1_s = wdata;
            end else begin
                rdata1_s = regs_r[raddr1];
            end
            // The last outstanding writer retiring this cycle is covered by the bypass.
            if (cnt_r[raddr1] > CNT_ONE) begin
                busy1_s = 1'b1;
            end else if (cnt_r[raddr1] == CNT_ONE) begin
                busy1_s = !(we && (waddr == raddr1));
            end else begin
                busy1_s = 1'b0;
            end
        end
    end

    // Read port 2: identical resolution, independent of port 1.
    always_comb begin
        rdata2_s = DATA_ZERO;
        busy2_s  = 1'b0;
        if (rst || !re2 || (raddr2 == ADDR_X0)) begin
            rdata2_s = DATA_ZERO;
            busy2_s  = 1'b0;
        end else begin
            if (we && (waddr == raddr2)) begin
                rdata2_s = wdata;
            end else begin
                rdata2_s = regs_r[raddr2];
            end
            if (cnt_r[raddr2] > CNT_ONE) begin
                busy2_s = 1'b1;
            end else if (cnt_r[raddr2] == CNT_ONE) begin
                busy2_s = !(we && (waddr == raddr2));
            end else begin
                busy2_s = 1'b0;
            end
        end
    end

    // Issue is refused only when the counter is full and no retire frees a slot.
    always_comb begin
        issue_stall_s = 1'b0;
        if (rst || !issue_valid || (issue_addr == ADDR_X0)) begin
            issue_stall_s = 1'b0;
        end else begin
            issue_stall_s = (cnt_r[issue_addr] == CNT_MAX) && !(we && (waddr == issue_addr));
        end
    end

    // Per-register increment/decrement requests; x0 never tracks writers.
    always_comb begin
        inc_s = {NREG{1'b0}};
        dec_s = {NREG{1'b0}};
        for (int r = 1; r < NREG; r++) begin
            inc_s[r] = issue_valid && (issue_addr == ADDR_W'(r)) && !issue_stall_s;
            dec_s[r] = we && (waddr == ADDR_W'(r)) && (cnt_r[r] != CNT_ZERO);
        end
    end

    // Storage, scoreboard counters and the sticky spurious-write-back flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_r[r] <= DATA_ZERO;
                cnt_r[r]  <= CNT_ZERO;
            end
            wb_err_r <= 1'b0;
        end else begin
            if (we && (waddr != ADDR_X0)) begin
                regs_r[waddr] <= wdata;
                if (cnt_r[waddr] == CNT_ZERO) begin
                    wb_err_r <= 1'b1;
                end else begin
                    wb_err_r <= wb_err_r;
                end
            end else begin
                wb_err_r <= wb_err_r;
            end
            for (int r = 1; r < NREG; r++) begin
                if (inc_s[r] && !dec_s[r]) begin
                    cnt_r[r] <= cnt_r[r] + CNT_ONE;
                end else if (dec_s[r] && !inc_s[r]) begin
                    cnt_r[r] <= cnt_r[r] - CNT_ONE;
                end else begin
                    cnt_r[r] <= cnt_r[r];
                end
            end
        end
    end

    assign rdata1      = rdata1_s;
    assign rdata2      = rdata2_s;
    assign busy1       = busy1_s;
    assign busy2       = busy2_s;
    assign issue_stall = issue_stall_s;
    assign wb_err      = wb_err_r;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Architectural integer register file with a per-register pending-write scoreboard. It is the consumer end of the execute/write-back interface (wd/wreg/wdata), and it also serves the decode stage's two operand read ports. Write-back is sequential. Reads are combinational, with same-cycle write-through bypass. The scoreboard counts in-flight writers per register, so decode can detect RAW hazards and throttle issue.

Parameters:
DATA_W, 32, register width (RegBus)
ADDR_W, 5, register index width (RegAddrBus); 2**ADDR_W registers
MAX_PEND, 3, maximum outstanding writers tracked per register; counter width = clog2(MAX_PEND+1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
we  in  1  write-back enable (wreg from pipeline)
waddr  in  ADDR_W  write-back destination (wd)
wdata  in  DATA_W  write-back data
re1  in  1  read port 1 enable
raddr1  in  ADDR_W  read port 1 index
rdata1  out  DATA_W  read port 1 data
busy1  out  1  read port 1 operand not yet available
re2  in  1  read port 2 enable
raddr2  in  ADDR_W  read port 2 index
rdata2  out  DATA_W  read port 2 data
busy2  out  1  read port 2 operand not yet available
issue_valid  in  1  decode issuing an instruction that writes issue_addr
issue_addr  in  ADDR_W  destination of issuing instruction
issue_stall  out  1  issue refused this cycle (counter saturated)
wb_err  out  1  sticky: write-back to register with zero pending count

Behaviour:
- Reset: synchronous, active-high. On a clock edge with rst=1, all registers are cleared to 0, all pending counters to 0, and wb_err to 0. While rst=1, rdata1/rdata2=0, busy1/busy2=0, issue_stall=0, and we/issue_valid are ignored. Reset mid-operation discards all in-flight state.
- Register x0: reads always return 0. Writes are ignored. Issue to x0 never changes its counter, never stalls, and never flags wb_err.
- Write: on an edge with we=1 and waddr!=0, regs[waddr] <= wdata. Write latency is 1 cycle: the value appears in storage on the next cycle, but it is visible on read ports in the same cycle through bypass.
- Read port n (combinational), in priority order:
  - rst=1 -> 0
  - re_n=0 -> 0
  - raddr_n=0 -> 0
  - we=1 and waddr==raddr_n -> wdata (bypass)
  - otherwise regs[raddr_n]
- Pending counter cnt[r], updated on each edge, for r!=0:
  - inc = issue_valid and issue_addr==r and not issue_stall
  - dec = we and waddr==r and cnt[r]!=0
  - inc only -> +1; dec only -> -1; both -> unchanged
- issue_stall = issue_valid and issue_addr!=0 and cnt[issue_addr]==MAX_PEND and not (we and waddr==issue_addr). A same-cycle retire frees the slot, so no stall in that case.
- busy_n = re_n and raddr_n!=0 and (cnt[raddr_n] > 1, or cnt[raddr_n]==1 and not (we and waddr==raddr_n)). The last pending writer being resolved by bypass is not busy. Same-cycle issue to raddr_n does not affect busy_n: the issuing instruction is younger than the reader.
- wb_err: set on an edge where we=1, waddr!=0 and cnt[waddr]==0. The write is still performed. Cleared only by rst.
- Both read ports may address the same register simultaneously; each resolves independently.

Test Plan:
- Reset/x0: assert rst 2 cycles, then read all 32 regs on both ports -> all 0; write x0=0xDEADBEEF, read x0 -> 0, wb_err stays 0.
- Write/read and bypass:
  - issue x5, next cycle we=1 waddr=5 wdata=0x12345678 with re1 raddr1=5 -> same cycle rdata1=0x12345678, busy1=0.
  - following cycle with we=0 -> rdata1=0x12345678, busy1=0.
- Scoreboard RAW: issue x7 twice (cnt=2), read x7 -> busy=1; retire one write of 0xA -> busy stays 1 that cycle; retire second write 0xB -> bypass 0xB, busy=0; cnt returns to 0.
- Saturation: issue x3 three times; fourth issue -> issue_stall=1, cnt stays 3; repeat fourth issue in the same cycle as we waddr=3 -> issue_stall=0, cnt stays 3.
- Spurious write-back: we=1 waddr=9 with cnt[9]=0 -> wb_err=1 next cycle and remains set; reg9 updated; rst clears wb_err.
- Reset mid-flight: issue x4 twice, assert rst one cycle -> busy for x4=0, reg4=0, issue_stall=0; a later write to x4 sets wb_err (counter was cleared).
